// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared types and constants for the bit-serial adder.
//   - sa_state_t       : controller state encoding (IDLE, RUN, DONE)
//   - SA_WIDTH_DEFAULT : default operand width in bits
package serial_adder_pkg;

    localparam int SA_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sa_state_t;

endpackage

// File: rtl/full_adder.sv
// full_adder
//   Existing one-bit full-adder cell, reused unchanged by serial_adder.
//   Ports:
//     A, B, Cin : operand bits and carry-in
//     S         : sum bit
//     Cout      : carry-out
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial adder: one full_adder cell plus a carry flop, processing one
//   operand bit per clock, LSB first. An addition takes WIDTH RUN cycles
//   followed by a single DONE cycle.
//   Ports:
//     clk, rst_n    : clock, synchronous active-low reset
//     start         : request an addition (honoured only in IDLE)
//     a, b, cin     : operands and carry-in, captured on accepted start
//     busy          : high in RUN and DONE
//     done          : one-cycle pulse, sum/cout valid
//     sum, cout     : registered result, held until the next completion
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // One extra bit keeps the counter meaningful for WIDTH=1.
    localparam int                CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    sa_state_t        state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q,  carry_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             cout_q,   cout_d;

    logic             fa_s;
    logic             fa_cout;
    logic [WIDTH-1:0] sum_sh_next;

    full_adder u_fa (
        .A    (a_sh_q[0]),
        .B    (b_sh_q[0]),
        .Cin  (carry_q),
        .S    (fa_s),
        .Cout (fa_cout)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at LSB.
    generate
        if (WIDTH == 1) begin : g_sh1
            assign sum_sh_next = fa_s;
        end else begin : g_shn
            assign sum_sh_next = {fa_s, sum_sh_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    carry_d  = cin;
                    sum_sh_d = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                sum_sh_d = sum_sh_next;
                carry_d  = fa_cout;
                cnt_d    = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    // Outputs are written straight from the final shift so
                    // they are already valid during the DONE cycle.
                    sum_d   = sum_sh_next;
                    cout_d  = fa_cout;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Scoreboard bench for serial_adder at WIDTH = 8, 1 and 16. Directed cases
//   run on the 8-bit instance; all three instances then run back-to-back
//   random additions with start held high. Expected {cout,sum} values are
//   pushed when a request is issued; a per-instance monitor pops and compares
//   on every done and also checks done spacing during the random phase.
module tb_serial_adder;

    localparam int NRAND = 1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;
    bit   rand_go = 1'b0;
    bit   fin [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_w
        localparam int W = (g == 0) ? 8 : ((g == 1) ? 1 : 16);

        logic         start = 1'b0;
        logic         cin   = 1'b0;
        logic [W-1:0] a     = '0;
        logic [W-1:0] b     = '0;
        logic         busy;
        logic         done;
        logic         cout;
        logic [W-1:0] sum;

        logic [W:0]   exp_q [$];
        int           last_done = -1;
        bit           space_chk = 1'b0;

        serial_adder #(.WIDTH(W)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start),
            .a     (a),
            .b     (b),
            .cin   (cin),
            .busy  (busy),
            .done  (done),
            .sum   (sum),
            .cout  (cout)
        );

        // Monitor: compare every completion against the oldest expectation.
        always @(negedge clk) begin
            logic [W:0] e;
            if (rst_n && done) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL w%0d unexpected_done got=%h expected=none", W, {cout, sum});
                end else begin
                    e = exp_q.pop_front();
                    if ({cout, sum} !== e) begin
                        errors++;
                        $display("FAIL w%0d result got=%h expected=%h", W, {cout, sum}, e);
                    end
                end
                if (space_chk && last_done >= 0) begin
                    checks++;
                    if (cyc - last_done != W + 2) begin
                        errors++;
                        $display("FAIL w%0d done_spacing got=%0d expected=%0d", W, cyc - last_done, W + 2);
                    end
                end
                last_done = cyc;
            end
        end

        // Random back-to-back: start stays high, so a new request is accepted
        // every W+2 edges; operands are swapped between acceptances.
        initial begin
            wait (rand_go);
            @(negedge clk);
            last_done = -1;
            space_chk = 1'b1;
            for (int i = 0; i < NRAND; i++) begin
                a     = W'($urandom());
                b     = W'($urandom());
                cin   = 1'($urandom_range(0, 1));
                start = 1'b1;
                exp_q.push_back({1'b0, a} + {1'b0, b} + (W + 1)'(cin));
                repeat (W + 2) @(posedge clk);
                @(negedge clk);
            end
            start = 1'b0;
            fin[g] = 1'b1;
        end
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, want);
        end
    endtask

    // Issue a one-cycle start on the 8-bit instance; t_raise is the cycle
    // count seen just before the accepting edge.
    task automatic add8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        input bit push, output int t_raise);
        @(negedge clk);
        g_w[0].a     = av;
        g_w[0].b     = bv;
        g_w[0].cin   = cv;
        g_w[0].start = 1'b1;
        t_raise      = cyc;
        if (push) g_w[0].exp_q.push_back({1'b0, av} + {1'b0, bv} + 9'(cv));
        @(negedge clk);
        g_w[0].start = 1'b0;
    endtask

    task automatic wait_done8(output int t_done);
        bit found = 1'b0;
        t_done = -1;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (g_w[0].done) begin
                found  = 1'b1;
                t_done = cyc;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL w8 done_timeout got=none expected=done");
        end
    endtask

    initial begin
        int t0, t1;

        // Reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", int'(g_w[0].busy), 0);
        check("reset_done", int'(g_w[0].done), 0);
        check("reset_sum",  int'(g_w[0].sum),  0);
        check("reset_cout", int'(g_w[0].cout), 0);
        rst_n = 1'b1;

        // Basic + latency (edges from start raise to done visible)
        add8(8'h03, 8'h05, 1'b0, 1'b1, t0);
        wait_done8(t1);
        check("latency", t1 - t0, 9);
        repeat (5) @(negedge clk);
        check("sum_hold", int'(g_w[0].sum), 8'h08);

        // Wrap-around
        add8(8'hFF, 8'h01, 1'b0, 1'b1, t0);
        wait_done8(t1);
        add8(8'hA5, 8'h5A, 1'b1, 1'b1, t0);
        wait_done8(t1);

        // Busy protection: extra starts in RUN and DONE must be dropped
        add8(8'h10, 8'h20, 1'b0, 1'b1, t0);
        repeat (2) @(negedge clk);
        g_w[0].a = 8'hFF; g_w[0].b = 8'hFF; g_w[0].start = 1'b1;
        @(negedge clk);
        g_w[0].start = 1'b0;
        repeat (5) @(negedge clk);
        check("done_in_done_cycle", int'(g_w[0].done), 1);
        g_w[0].a = 8'hFF; g_w[0].b = 8'hFF; g_w[0].start = 1'b1;
        @(negedge clk);
        g_w[0].start = 1'b0;
        repeat (25) @(negedge clk);
        check("busy_prot_sum",  int'(g_w[0].sum),  8'h30);
        check("busy_prot_cout", int'(g_w[0].cout), 0);
        check("busy_prot_idle", int'(g_w[0].busy), 0);

        // Reset during RUN: operation discarded, outputs cleared
        add8(8'h11, 8'h22, 1'b0, 1'b0, t0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_busy", int'(g_w[0].busy), 0);
        check("midrst_done", int'(g_w[0].done), 0);
        check("midrst_sum",  int'(g_w[0].sum),  0);
        check("midrst_cout", int'(g_w[0].cout), 0);
        repeat (15) @(negedge clk);
        add8(8'h7F, 8'h01, 1'b0, 1'b1, t0);
        wait_done8(t1);
        check("post_rst_latency", t1 - t0, 9);

        // Random back-to-back on all widths
        rand_go = 1'b1;
        for (int k = 0; k < 40000 && !(fin[0] && fin[1] && fin[2]); k++)
            @(posedge clk);
        checks++;
        if (!(fin[0] && fin[1] && fin[2])) begin
            errors++;
            $display("FAIL random_timeout got=%0d%0d%0d expected=111", fin[0], fin[1], fin[2]);
        end
        repeat (40) @(negedge clk);
        check("drain_w8",  g_w[0].exp_q.size(), 0);
        check("drain_w1",  g_w[1].exp_q.size(), 0);
        check("drain_w16", g_w[2].exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial, multi-cycle adder for two WIDTH-bit operands, built around the existing one-bit `full_adder` cell plus a carry flip-flop. It consumes that cell's `S`/`Cout` outputs one bit per clock, LSB first. It trades latency for area: WIDTH+1 cycles per addition, one full-adder instance regardless of WIDTH. It sits downstream of the full-adder cell and presents a start/busy/done handshake to whatever issues additions.

## Interface
Parameters:
- `WIDTH`, 8, operand and sum width in bits; legal range ≥ 1.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  rising-edge clock for all state.
- `rst_n`  in  1  synchronous reset, active-low, sampled on `clk` rising edge.
- `start`  in  1  request a new addition; honoured only in IDLE.
- `a`  in  WIDTH  operand A, sampled on accepted `start`.
- `b`  in  WIDTH  operand B, sampled on accepted `start`.
- `cin`  in  1  carry-in, sampled on accepted `start`.
- `busy`  out  1  high while in RUN or DONE.
- `done`  out  1  one-cycle pulse, result valid.
- `sum`  out  WIDTH  (a + b + cin) mod 2^WIDTH; registered, holds until the next completion.
- `cout`  out  1  carry out of bit WIDTH-1; registered, holds with `sum`.

## Operation
- **State machine:** IDLE, RUN, DONE.
- **IDLE:**
  - `busy`=0, `done`=0.
  - On `start`=1: load `a_sh`←`a`, `b_sh`←`b`, `carry`←`cin`, `sum_sh`←0, `cnt`←0; go to RUN.
- **RUN** (each cycle):
  - The `full_adder` sees `a_sh[0]`, `b_sh[0]`, `carry`.
  - `a_sh`, `b_sh` shift right by 1.
  - `sum_sh` shifts right with `S` entering at bit WIDTH-1.
  - `carry`←`Cout`; `cnt`←`cnt`+1.
  - When `cnt`==WIDTH-1 (last bit processed this cycle): go to DONE.
- **DONE:**
  - `done`=1, `busy`=1.
  - `sum` and `cout` already hold the final values, written on the RUN→DONE edge from the completed `sum_sh` and `carry`.
  - Next cycle: IDLE, unconditionally.
- **Ignored start:** `start` is ignored in RUN and DONE; it is not queued.
- **Output register updates:** `sum` and `cout` change only on the RUN→DONE transition. Intermediate shifting is never visible on the outputs.
- **Arithmetic:** unsigned modulo 2^WIDTH; overflow reported only via `cout`. `cnt` width is $clog2(WIDTH)+1 bits, sufficient for WIDTH=1.
- **Reset** (`rst_n`=0 at a rising edge), any state:
  - State→IDLE.
  - `busy`=0, `done`=0, `sum`=0, `cout`=0.
  - `carry`, `cnt`, and the shift registers →0.
  - Reset mid-RUN discards the operation; no `done` is produced.
- **Reset priority:** reset has priority over `start` in the same cycle.

## Timing
- Accepted `start` at edge T → `busy`=1 from T.
- Last bit is computed in the cycle ending at edge T+WIDTH.
- `done`=1 with valid `sum`/`cout` during the cycle after edge T+WIDTH.
- Latency from `start` accept to `done`: WIDTH+1 edges.
- Back-to-back throughput: one addition per WIDTH+2 cycles. A `start` held high continuously is accepted again in the first IDLE cycle after DONE.
- WIDTH=1: RUN lasts exactly one cycle.
- All outputs are driven from registers; there are no combinational paths from inputs to outputs.

## Structure
- **Shared package `serial_adder_pkg`:**
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t`.
  - Default width constant `SA_WIDTH_DEFAULT = 8`.
- **One sub-module:** the existing `full_adder` (ports `A`, `B`, `Cin`, `S`, `Cout`), instantiated once. No new arithmetic cell is written.
- **Expected RTL size:** FSM, counter, three shift registers, and output registers in roughly 150–200 lines.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles → `busy`=0, `done`=0, `sum`=0x00, `cout`=0 (WIDTH=8).
- **Basic and latency:** a=0x03, b=0x05, cin=0, `start` 1 cycle → `done` exactly 9 edges later, with `sum`=0x08 and `cout`=0; `sum` then holds 0x08 until the next completion.
- **Wrap-around:**
  - a=0xFF, b=0x01, cin=0 → `sum`=0x00, `cout`=1.
  - a=0xA5, b=0x5A, cin=1 → `sum`=0x00, `cout`=1.
- **Busy protection:** start a=0x10, b=0x20; pulse `start` with a=0xFF, b=0xFF during RUN and during DONE → single `done`, `sum`=0x30. Second request is not executed.
- **Reset mid-operation:** assert `rst_n`=0 at cycle 4 of RUN → no `done`, outputs zero. A fresh start with a=0x7F, b=0x01 then yields 0x80, `cout`=0.
- **Back-to-back and random:**
  - `start` held high for 1000 random a/b/cin triples → every `done` is spaced WIDTH+2 cycles apart.
  - Every `{cout,sum}` equals a+b+cin from a reference model.
  - Repeat with WIDTH=1 and WIDTH=16.
